// File: rtl/i281_loader_pkg.sv
// Shared definitions for the i281 boot loader: command codes and FSM states.
package i281_loader_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_CODE  = 2'b01,
        CMD_DATA  = 2'b10,
        CMD_START = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_DATA,
        ST_CSUM,
        ST_RUN
    } state_e;

endpackage

// File: rtl/i281_program_loader.sv
// Framed byte-stream boot loader: fills code/data memory, checks frame sums,
// then releases the CPU from reset and starts it on a START command.
module i281_program_loader
    import i281_loader_pkg::*;
#(
    parameter int CODE_AW = 6,
    parameter int DATA_AW = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               code_we,
    output logic [CODE_AW-1:0] code_addr,
    output logic [15:0]        code_wdata,
    output logic               data_we,
    output logic [DATA_AW-1:0] data_addr,
    output logic [7:0]         data_wdata,
    output logic               cpu_reset,
    output logic               cpu_run,
    output logic               error,
    output logic [7:0]         frames_ok
);

    state_e               state_q;
    logic                 is_code_q;
    logic [7:0]           cnt_q;
    logic [7:0]           sum_q;
    logic [7:0]           hi_q;
    logic [CODE_AW-1:0]   code_ptr_q;
    logic [DATA_AW-1:0]   data_ptr_q;
    logic                 code_we_q, data_we_q;
    logic [CODE_AW-1:0]   code_addr_q;
    logic [15:0]          code_wdata_q;
    logic [DATA_AW-1:0]   data_addr_q;
    logic [7:0]           data_wdata_q;
    logic                 cpu_reset_q, cpu_run_q, error_q;
    logic [7:0]           frames_ok_q;

    logic                 accept;
    logic [7:0]           sum_d;

    always_comb begin
        accept = in_valid && (state_q != ST_RUN);
        sum_d  = sum_q + in_byte;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            is_code_q    <= 1'b0;
            cnt_q        <= '0;
            sum_q        <= '0;
            hi_q         <= '0;
            code_ptr_q   <= '0;
            data_ptr_q   <= '0;
            code_we_q    <= 1'b0;
            data_we_q    <= 1'b0;
            code_addr_q  <= '0;
            code_wdata_q <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            cpu_run_q    <= 1'b0;
            error_q      <= 1'b0;
            frames_ok_q  <= '0;
        end else begin
            code_we_q <= 1'b0;
            data_we_q <= 1'b0;
            // One reset-free cycle in RUN before the run flag rises.
            if (state_q == ST_RUN) cpu_run_q <= 1'b1;
            if (accept) begin
                sum_q <= sum_d;
                case (state_q)
                    ST_IDLE: begin
                        sum_q <= in_byte;
                        case (cmd_e'(in_byte[7:6]))
                            CMD_CODE: begin
                                is_code_q  <= 1'b1;
                                code_ptr_q <= in_byte[CODE_AW-1:0];
                                state_q    <= ST_LEN;
                            end
                            CMD_DATA: begin
                                is_code_q  <= 1'b0;
                                data_ptr_q <= in_byte[DATA_AW-1:0];
                                state_q    <= ST_LEN;
                            end
                            CMD_START: begin
                                if (!error_q) begin
                                    cpu_reset_q <= 1'b0;
                                    state_q     <= ST_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                    ST_LEN: begin
                        cnt_q <= in_byte;
                        if (in_byte == 8'd0) state_q <= ST_CSUM;
                        else if (is_code_q)  state_q <= ST_HI;
                        else                 state_q <= ST_DATA;
                    end
                    ST_HI: begin
                        hi_q    <= in_byte;
                        state_q <= ST_LO;
                    end
                    ST_LO: begin
                        code_we_q    <= 1'b1;
                        code_addr_q  <= code_ptr_q;
                        code_wdata_q <= {hi_q, in_byte};
                        code_ptr_q   <= code_ptr_q + 1'b1;
                        cnt_q        <= cnt_q - 8'd1;
                        state_q      <= (cnt_q == 8'd1) ? ST_CSUM : ST_HI;
                    end
                    ST_DATA: begin
                        data_we_q    <= 1'b1;
                        data_addr_q  <= data_ptr_q;
                        data_wdata_q <= in_byte;
                        data_ptr_q   <= data_ptr_q + 1'b1;
                        cnt_q        <= cnt_q - 8'd1;
                        state_q      <= (cnt_q == 8'd1) ? ST_CSUM : ST_DATA;
                    end
                    ST_CSUM: begin
                        if (sum_d == 8'd0) begin
                            if (frames_ok_q != 8'hFF) frames_ok_q <= frames_ok_q + 8'd1;
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        in_ready   = (state_q != ST_RUN);
        code_we    = code_we_q;
        code_addr  = code_addr_q;
        code_wdata = code_wdata_q;
        data_we    = data_we_q;
        data_addr  = data_addr_q;
        data_wdata = data_wdata_q;
        cpu_reset  = cpu_reset_q;
        cpu_run    = cpu_run_q;
        error      = error_q;
        frames_ok  = frames_ok_q;
    end

endmodule

// File: tb/tb_i281_program_loader.sv
// Self-checking bench for i281_program_loader: directed frames plus random
// frames checked against a frame-level reference model.
module tb_i281_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, code_we, data_we, cpu_reset, cpu_run, error;
    logic [5:0]  code_addr;
    logic [15:0] code_wdata;
    logic [3:0]  data_addr;
    logic [7:0]  data_wdata, frames_ok;

    i281_program_loader #(.CODE_AW(6), .DATA_AW(4)) dut (
        .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .code_we(code_we), .code_addr(code_addr),
        .code_wdata(code_wdata), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .cpu_reset(cpu_reset), .cpu_run(cpu_run),
        .error(error), .frames_ok(frames_ok)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit   is_code;
        int   addr;
        int   data;
        time  t;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  m_frames = 0;
    bit  m_error = 1'b0;

    always @(negedge clock) begin
        wr_t w;
        if (code_we) begin
            w.is_code = 1'b1; w.addr = int'(code_addr); w.data = int'(code_wdata); w.t = $time;
            obs_q.push_back(w);
        end
        if (data_we) begin
            w.is_code = 1'b0; w.addr = int'(data_addr); w.data = int'(data_wdata); w.t = $time;
            obs_q.push_back(w);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".in_ready"},   32'(in_ready),   32'd1);
        chk({tag, ".code_we"},    32'(code_we),    32'd0);
        chk({tag, ".data_we"},    32'(data_we),    32'd0);
        chk({tag, ".code_addr"},  32'(code_addr),  32'd0);
        chk({tag, ".code_wdata"}, 32'(code_wdata), 32'd0);
        chk({tag, ".data_addr"},  32'(data_addr),  32'd0);
        chk({tag, ".data_wdata"}, 32'(data_wdata), 32'd0);
        chk({tag, ".cpu_reset"},  32'(cpu_reset),  32'd1);
        chk({tag, ".cpu_run"},    32'(cpu_run),    32'd0);
        chk({tag, ".error"},      32'(error),      32'd0);
        chk({tag, ".frames_ok"},  32'(frames_ok),  32'd0);
    endtask

    // Drives one byte after `gap` idle cycles; returns the time of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output time t);
        int n;
        repeat (gap) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        @(negedge clock);
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $error("FAIL accept_timeout: byte %0h not accepted within 50 cycles", b);
            t = 0;
        end else begin
            @(posedge clock);
            t = $time;
        end
    endtask

    function automatic bq_t make_frame(input bit code, input int addr, input int len, input bit bad);
        bq_t fr;
        int  sum;
        fr.push_back(code ? 8'(8'h40 | (addr & 63)) : 8'(8'h80 | (addr & 63)));
        fr.push_back(8'(len));
        for (int i = 0; i < (code ? 2 * len : len); i++) fr.push_back(8'($urandom));
        sum = 0;
        foreach (fr[i]) sum += int'(fr[i]);
        fr.push_back(8'((256 - (sum % 256)) % 256 + (bad ? int'($urandom_range(1, 255)) : 0)));
        return fr;
    endfunction

    // gapmode < 0 picks a random 0..2 idle gap before each byte.
    task automatic run_frame(input bq_t fr, input int gapmode, input string tag);
        bit  code;
        int  addr, len, sum, gap;
        time t;
        wr_t e;
        code = (fr[0][7:6] == 2'b01);
        addr = code ? int'(fr[0][5:0]) : int'(fr[0][3:0]);
        len  = int'(fr[1]);
        sum  = 0;
        foreach (fr[i]) sum += int'(fr[i]);
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < fr.size(); i++) begin
            gap = (gapmode < 0) ? int'($urandom_range(0, 2)) : gapmode;
            send_byte(fr[i], gap, t);
            if (i >= 2 && i < fr.size() - 1) begin
                if (code && ((i - 2) % 2 == 1)) begin
                    e.is_code = 1'b1;
                    e.addr = (addr + (i - 3) / 2) % 64;
                    e.data = int'({fr[i-1], fr[i]});
                    e.t = t + 5;
                    exp_q.push_back(e);
                end else if (!code) begin
                    e.is_code = 1'b0;
                    e.addr = (addr + (i - 2)) % 16;
                    e.data = int'(fr[i]);
                    e.t = t + 5;
                    exp_q.push_back(e);
                end
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        if (sum % 256 == 0) m_frames = (m_frames < 255) ? m_frames + 1 : 255;
        else m_error = 1'b1;
        chk({tag, ".frames_ok"}, 32'(frames_ok), 32'(m_frames));
        chk({tag, ".error"}, 32'(error), 32'(m_error));
        chk({tag, ".n_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({tag, ".kind"}, 32'(obs_q[i].is_code), 32'(exp_q[i].is_code));
            chk({tag, ".addr"}, 32'(obs_q[i].addr), 32'(exp_q[i].addr));
            chk({tag, ".data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
            chk({tag, ".time"}, 32'(obs_q[i].t), 32'(exp_q[i].t));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;
        #2;
        check_reset_vals(tag);
        m_frames = 0;
        m_error = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t fr;
        time t;
        int  nobs;

        #12;
        check_reset_vals("por");
        @(negedge clock);
        reset = 1'b1;

        fr = '{8'h83, 8'h02, 8'hAA, 8'h55, 8'h7C};
        run_frame(fr, 0, "data_b2b");
        if (obs_q.size() == 2) begin
            chk("data_b2b.addr0", 32'(obs_q[0].addr), 32'd3);
            chk("data_b2b.byte0", 32'(obs_q[0].data), 32'hAA);
            chk("data_b2b.addr1", 32'(obs_q[1].addr), 32'd4);
            chk("data_b2b.byte1", 32'(obs_q[1].data), 32'h55);
        end

        run_frame(fr, 1, "data_toggle");

        fr = '{8'h7F, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
        run_frame(fr, 0, "code_wrap");
        if (obs_q.size() == 2) begin
            chk("code_wrap.addr0", 32'(obs_q[0].addr), 32'd63);
            chk("code_wrap.word0", 32'(obs_q[0].data), 32'h1234);
            chk("code_wrap.addr1", 32'(obs_q[1].addr), 32'd0);
            chk("code_wrap.word1", 32'(obs_q[1].data), 32'hABCD);
        end

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_byte(8'($urandom_range(0, 63)), 0, t);
                @(negedge clock);
                in_valid = 1'b0;
            end
            fr = make_frame(1'($urandom), int'($urandom_range(0, 63)),
                            int'($urandom_range(0, 20)), ($urandom_range(0, 4) == 0));
            run_frame(fr, -1, "rand");
        end

        do_reset("rst_pre_mid");
        obs_q.delete();
        send_byte(8'h45, 0, t);
        send_byte(8'h02, 0, t);
        send_byte(8'h12, 0, t);
        do_reset("rst_mid");
        chk("rst_mid.no_strobe", 32'(obs_q.size()), 32'd0);
        fr = '{8'h83, 8'h02, 8'hAA, 8'h55, 8'h7C};
        run_frame(fr, 0, "after_rst");

        fr = '{8'h83, 8'h02, 8'hAA, 8'h55, 8'h7D};
        run_frame(fr, 0, "bad_csum");
        send_byte(8'hC0, 0, t);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        chk("refused.cpu_reset", 32'(cpu_reset), 32'd1);
        chk("refused.cpu_run",   32'(cpu_run),   32'd0);
        chk("refused.in_ready",  32'(in_ready),  32'd1);
        fr = make_frame(1'b0, 9, 3, 1'b0);
        run_frame(fr, -1, "after_err");

        do_reset("rst_pre_start");
        fr = make_frame(1'b1, 20, 4, 1'b0);
        run_frame(fr, -1, "pre_start");
        send_byte(8'hC0, 0, t);
        @(negedge clock);
        in_byte = 8'h83;
        chk("start.n1.cpu_reset", 32'(cpu_reset), 32'd0);
        chk("start.n1.in_ready",  32'(in_ready),  32'd0);
        chk("start.n1.cpu_run",   32'(cpu_run),   32'd0);
        @(negedge clock);
        chk("start.n2.cpu_run",   32'(cpu_run),   32'd1);
        obs_q.delete();
        repeat (6) @(negedge clock);
        chk("run.in_ready",  32'(in_ready),  32'd0);
        chk("run.cpu_run",   32'(cpu_run),   32'd1);
        chk("run.frames_ok", 32'(frames_ok), 32'(m_frames));
        nobs = obs_q.size();
        chk("run.no_strobe", 32'(nobs), 32'd0);
        in_valid = 1'b0;

        do_reset("rst_in_run");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i281_program_loader.md
# i281_program_loader

Byte-stream boot loader that sits directly upstream of `i281_toplevel`. It accepts framed bytes over a valid/ready handshake and writes 16-bit instruction words into code memory and 8-bit values into data memory. While loading it holds the CPU in reset. On a START command it releases reset and then asserts `run`. Frames are checksummed; a bad frame sets a sticky error that blocks START.

## Interface
- `CODE_AW`, 6, code memory address width (64 words)
- `DATA_AW`, 4, data memory address width (16 bytes)
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `in_byte`  in  8  stream byte
- `in_valid`  in  1  `in_byte` is valid
- `in_ready`  out  1  loader can accept a byte
- `code_we`  out  1  code memory write strobe, one cycle
- `code_addr`  out  CODE_AW  code write address
- `code_wdata`  out  16  code write word
- `data_we`  out  1  data memory write strobe, one cycle
- `data_addr`  out  DATA_AW  data write address
- `data_wdata`  out  8  data write byte
- `cpu_reset`  out  1  active-high reset to toplevel
- `cpu_run`  out  1  run to toplevel
- `error`  out  1  sticky checksum error
- `frames_ok`  out  8  count of good frames, saturates at 255

## Operation
- Byte accepted on a rising edge when `in_valid & in_ready`. `in_ready` = 1 in every state except RUN.
- Command byte: bits[7:6] select the command, bits[5:0] give the start address.
  - 00: NOP, single byte.
  - 01: CODE frame.
  - 10: DATA frame; address uses bits[3:0], bits[5:4] ignored.
  - 11: START, single byte.
- Frame (CODE/DATA) layout: command, length L (0–255), payload, checksum.
  - CODE payload = L words, high byte first.
  - DATA payload = L bytes.
- Checksum: 8-bit sum of all frame bytes including the checksum must equal 0x00.
  - Match: `frames_ok` increments.
  - Mismatch: `error` is set.
  - In both cases the FSM returns to IDLE. Writes already issued are not undone.
- Addresses increment after each write and wrap modulo 2^CODE_AW or 2^DATA_AW.
- L = 0: LEN goes straight to CSUM.
- START accepted while `error` = 1: ignored, FSM stays in IDLE.
- START accepted while `error` = 0: enter RUN. RUN is left only by `reset`.
- FSM states:
  - IDLE → LEN (CODE/DATA), RUN (START), IDLE (NOP or refused START).
  - LEN → HI (CODE, L>0), DATA (DATA, L>0), CSUM (L=0).
  - HI → LO.
  - LO → HI if words remain, else CSUM.
  - DATA → DATA if bytes remain, else CSUM.
  - CSUM → IDLE.
- Write-data outputs hold their last value between strobes.
- The loader never resets memory contents.

## Timing
- Reset values:
  - `in_ready` = 1 (state IDLE).
  - `code_we` = `data_we` = 0.
  - Addresses and write data = 0.
  - `cpu_reset` = 1, `cpu_run` = 0.
  - `error` = 0, `frames_ok` = 0.
- Write strobes are registered. `code_we` is high for exactly the cycle after the edge that accepts a LO byte; `data_we` likewise after a DATA byte. Address and data are valid in that same cycle.
- HI byte is latched internally; no strobe is issued for it.
- `frames_ok` and `error` update in the cycle after the checksum byte is accepted.
- START accepted at edge N:
  - `in_ready` = 0 and `cpu_reset` = 0 from N+1.
  - `cpu_run` = 1 from N+2 (one reset-free cycle before run).
- Back-to-back bytes are accepted every cycle; gaps in `in_valid` only stall the FSM.
- `reset` asserted at any point, including mid-frame or in RUN:
  - Immediate return to reset values and IDLE.
  - A partial word is discarded with no strobe.

## Structure
- Shared package `i281_loader_pkg`:
  - Command codes `CMD_NOP`, `CMD_CODE`, `CMD_DATA`, `CMD_START`.
  - FSM state enum.
- Single module `i281_program_loader` containing the FSM, payload counter, checksum accumulator and address counters. No sub-module is warranted.

## Test plan
- DATA frame 0x83, 0x02, 0xAA, 0x55, 0x7C sent back-to-back → `data_we` pulses with addr 3 / 0xAA, then addr 4 / 0x55; `error` = 0; `frames_ok` = 1.
- CODE frame 0x7F, 0x02, 0x12, 0x34, 0xAB, 0xCD, 0xC1 → `code_we` writes addr 63 = 0x1234, then addr 0 = 0xABCD (wrap); `frames_ok` = 1.
- Same DATA frame with checksum 0x7D → writes still occur and `error` = 1; a following 0xC0 leaves `cpu_reset` = 1, `cpu_run` = 0, `in_ready` = 1.
- Good frame, then 0xC0 at edge N → `cpu_reset` falls at N+1 and `cpu_run` rises at N+2; `in_ready` stays 0 and further bytes are not consumed.
- CODE frame with `reset` pulled low after the HI byte → no `code_we`, all outputs return to reset values; a following good DATA frame completes normally.
- First test's frame with `in_valid` toggling every other cycle → identical writes and counters; strobes occur one cycle after each accepting edge.
